// File: rtl/alu_pkg.sv
// Shared types for the ALU writeback stage: opcode encoding, flag bit positions
// and the packed result/flags entry carried through the skid buffer.
package alu_pkg;

    localparam int ALU_N   = 6;
    localparam int ALU_OPW = 4;

    typedef enum logic [ALU_OPW-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_MOD = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_AND = 4'd7,
        OP_OR  = 4'd8,
        OP_XOR = 4'd9,
        OP_MOV = 4'd10
    } opcode_e;

    localparam logic [ALU_OPW-1:0] OP_LAST = 4'd10;

    localparam int FLG_Z   = 3;
    localparam int FLG_NEG = 2;
    localparam int FLG_C   = 1;
    localparam int FLG_ERR = 0;

    typedef struct packed {
        logic [2*ALU_N-1:0] result;
        logic [3:0]         flags;
    } alu_entry_t;

endpackage

// File: rtl/alu_result_sel.sv
// Opcode result mux with Z/NEG/C/ERR flag generation.
// Latency: combinational. Backpressure: none, pure function of the inputs.
module alu_result_sel
    import alu_pkg::*;
#(
    parameter int N   = ALU_N,
    parameter int OPW = ALU_OPW
) (
    input  logic [OPW-1:0] opcode,
    input  logic           sm_mode,
    input  logic [N-1:0]   opb,
    input  logic [N:0]     sum_raw,
    input  logic [N:0]     sub_raw,
    input  logic [N:0]     div_raw,
    input  logic [N:0]     mod_raw,
    input  logic [N:0]     shl_raw,
    input  logic [N:0]     shr_raw,
    input  logic [N:0]     and_raw,
    input  logic [N:0]     or_raw,
    input  logic [N:0]     xor_raw,
    input  logic [N-1:0]   mov_res,
    input  logic [N-1:0]   sum_sm,
    input  logic [N-1:0]   sub_sm,
    input  logic [N-1:0]   div_sm,
    input  logic [N-1:0]   mod_sm,
    input  logic [2*N-1:0] mult_raw,
    input  logic [2*N-1:0] mult_sm,
    output alu_entry_t     entry
);

    localparam int RW = 2 * N;

    logic [RW-1:0] sel;
    logic          neg;
    logic          carry;
    logic          divByZero;
    logic          illegal;
    logic          err;

    // Bit N of the raw buses is the carry/overflow lane, never part of the value.
    logic unusedRawTop;
    assign unusedRawTop = ^{div_raw[N], mod_raw[N], shr_raw[N], and_raw[N], or_raw[N], xor_raw[N]};

    assign illegal = (opcode > OP_LAST);

    always_comb begin
        sel       = '0;
        neg       = 1'b0;
        carry     = 1'b0;
        divByZero = 1'b0;
        case (opcode)
            OP_ADD: begin
                sel   = sm_mode ? RW'(sum_sm) : RW'(sum_raw[N-1:0]);
                neg   = sm_mode & sel[N-1];
                carry = sum_raw[N];
            end
            OP_SUB: begin
                sel   = sm_mode ? RW'(sub_sm) : RW'(sub_raw[N-1:0]);
                neg   = sm_mode & sel[N-1];
                carry = sub_raw[N];
            end
            OP_MUL: begin
                sel   = sm_mode ? mult_sm : mult_raw;
                neg   = sm_mode & sel[RW-1];
                carry = |mult_raw[RW-1:N];
            end
            OP_DIV: begin
                sel       = sm_mode ? RW'(div_sm) : RW'(div_raw[N-1:0]);
                neg       = sm_mode & sel[N-1];
                divByZero = (opb == '0);
            end
            OP_MOD: begin
                sel       = sm_mode ? RW'(mod_sm) : RW'(mod_raw[N-1:0]);
                neg       = sm_mode & sel[N-1];
                divByZero = (opb == '0);
            end
            OP_SHL: begin
                sel   = RW'(shl_raw[N-1:0]);
                carry = shl_raw[N];
            end
            OP_SHR: sel = RW'(shr_raw[N-1:0]);
            OP_AND: sel = RW'(and_raw[N-1:0]);
            OP_OR:  sel = RW'(or_raw[N-1:0]);
            OP_XOR: sel = RW'(xor_raw[N-1:0]);
            OP_MOV: sel = RW'(mov_res);
            default: ;
        endcase
    end

    assign err = illegal | divByZero;

    // An error entry is canonical: zero result, Z and ERR only.
    always_comb begin
        entry = '0;
        if (err) begin
            entry.flags[FLG_Z]   = 1'b1;
            entry.flags[FLG_ERR] = 1'b1;
        end else begin
            entry.result         = sel;
            entry.flags[FLG_Z]   = (sel == '0);
            entry.flags[FLG_NEG] = neg;
            entry.flags[FLG_C]   = carry;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU writeback stage: result select + flags into a 2-entry skid buffer (optional stats: ALU_STAGE_STATS_EN).
// Latency: 1 cycle from accept to out_valid; throughput 1/cycle while out_ready is high.
// Backpressure: in_ready drops only when both entries are full; decoded from state, no path from out_ready.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int N   = ALU_N,
    parameter int OPW = ALU_OPW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] opcode,
    input  logic           sm_mode,
    input  logic [N-1:0]   opb,
    input  logic [N:0]     sum_raw,
    input  logic [N:0]     sub_raw,
    input  logic [N:0]     div_raw,
    input  logic [N:0]     mod_raw,
    input  logic [N:0]     shl_raw,
    input  logic [N:0]     shr_raw,
    input  logic [N:0]     and_raw,
    input  logic [N:0]     or_raw,
    input  logic [N:0]     xor_raw,
    input  logic [N-1:0]   mov_res,
    input  logic [N-1:0]   sum_sm,
    input  logic [N-1:0]   sub_sm,
    input  logic [N-1:0]   div_sm,
    input  logic [N-1:0]   mod_sm,
    input  logic [2*N-1:0] mult_raw,
    input  logic [2*N-1:0] mult_sm,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] result,
    output logic [3:0]     flags
`ifdef ALU_STAGE_STATS_EN
    ,
    output logic [15:0]    ops_count,
    output logic [15:0]    err_count
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } bufState_e;

    bufState_e  state;
    bufState_e  stateNext;
    alu_entry_t selEntry;
    alu_entry_t head;
    alu_entry_t skid;
    logic       loadHead;
    logic       loadSkid;
    logic       skidToHead;

    alu_result_sel #(.N(N), .OPW(OPW)) u_sel (
        .opcode   (opcode),
        .sm_mode  (sm_mode),
        .opb      (opb),
        .sum_raw  (sum_raw),
        .sub_raw  (sub_raw),
        .div_raw  (div_raw),
        .mod_raw  (mod_raw),
        .shl_raw  (shl_raw),
        .shr_raw  (shr_raw),
        .and_raw  (and_raw),
        .or_raw   (or_raw),
        .xor_raw  (xor_raw),
        .mov_res  (mov_res),
        .sum_sm   (sum_sm),
        .sub_sm   (sub_sm),
        .div_sm   (div_sm),
        .mod_sm   (mod_sm),
        .mult_raw (mult_raw),
        .mult_sm  (mult_sm),
        .entry    (selEntry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // in_ready is 1 in EMPTY/ONE, so in_valid alone means an accept there.
    always_comb begin
        stateNext  = state;
        loadHead   = 1'b0;
        loadSkid   = 1'b0;
        skidToHead = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_valid) begin
                    loadHead  = 1'b1;
                    stateNext = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_valid && out_ready) begin
                    loadHead = 1'b1;
                end else if (in_valid) begin
                    loadSkid  = 1'b1;
                    stateNext = ST_TWO;
                end else if (out_ready) begin
                    stateNext = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_ready) begin
                    skidToHead = 1'b1;
                    stateNext  = ST_ONE;
                end
            end
            default: stateNext = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (loadHead) begin
                head <= selEntry;
            end else if (skidToHead) begin
                head <= skid;
            end
            if (loadSkid) begin
                skid <= selEntry;
            end
        end
    end

    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign result    = head.result;
    assign flags     = head.flags;

`ifdef ALU_STAGE_STATS_EN
    logic accept;
    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_count <= '0;
            err_count <= '0;
        end else if (accept) begin
            if (ops_count != 16'hFFFF) begin
                ops_count <= ops_count + 16'd1;
            end
            if (selEntry.flags[FLG_ERR] && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed and randomized checks of alu_result_stage against a queue-based reference model.
module tb_alu_result_stage;

    localparam int N   = 6;
    localparam int OPW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [OPW-1:0] opcode = '0;
    logic           sm_mode = 1'b0;
    logic [N-1:0]   opb = '0;
    logic [N:0]     sum_raw = '0, sub_raw = '0, div_raw = '0, mod_raw = '0, shl_raw = '0;
    logic [N:0]     shr_raw = '0, and_raw = '0, or_raw = '0, xor_raw = '0;
    logic [N-1:0]   mov_res = '0, sum_sm = '0, sub_sm = '0, div_sm = '0, mod_sm = '0;
    logic [2*N-1:0] mult_raw = '0, mult_sm = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] result;
    logic [3:0]     flags;
`ifdef ALU_STAGE_STATS_EN
    logic [15:0]    ops_count;
    logic [15:0]    err_count;
    int             opsModel;
    int             errModel;
`endif

    int             assertCount = 0;
    int             failCount = 0;
    logic [15:0]    modelQ[$];
    logic [15:0]    expEntry;
    bit             acc;
    bit             pop;

    alu_result_stage #(.N(N), .OPW(OPW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .sm_mode   (sm_mode),
        .opb       (opb),
        .sum_raw   (sum_raw),
        .sub_raw   (sub_raw),
        .div_raw   (div_raw),
        .mod_raw   (mod_raw),
        .shl_raw   (shl_raw),
        .shr_raw   (shr_raw),
        .and_raw   (and_raw),
        .or_raw    (or_raw),
        .xor_raw   (xor_raw),
        .mov_res   (mov_res),
        .sum_sm    (sum_sm),
        .sub_sm    (sub_sm),
        .div_sm    (div_sm),
        .mod_sm    (mod_sm),
        .mult_raw  (mult_raw),
        .mult_sm   (mult_sm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
`ifdef ALU_STAGE_STATS_EN
        ,
        .ops_count (ops_count),
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected {Z,NEG,C,ERR,result[11:0]} from the current stimulus, by plain arithmetic.
    function automatic logic [15:0] refEntry();
        int o = int'(opcode);
        int r = 0;
        bit neg = 0;
        bit c = 0;
        bit err;
        bit z;
        err = (o > 10) || ((o == 3 || o == 4) && opb == 0);
        if (!err) begin
            case (o)
                0: begin r = sm_mode ? int'(sum_sm) : int'(sum_raw) % 64; c = sum_raw >= 64; neg = sm_mode && r >= 32; end
                1: begin r = sm_mode ? int'(sub_sm) : int'(sub_raw) % 64; c = sub_raw >= 64; neg = sm_mode && r >= 32; end
                2: begin r = sm_mode ? int'(mult_sm) : int'(mult_raw); c = mult_raw >= 64; neg = sm_mode && r >= 2048; end
                3: begin r = sm_mode ? int'(div_sm) : int'(div_raw) % 64; neg = sm_mode && r >= 32; end
                4: begin r = sm_mode ? int'(mod_sm) : int'(mod_raw) % 64; neg = sm_mode && r >= 32; end
                5: begin r = int'(shl_raw) % 64; c = shl_raw >= 64; end
                6: r = int'(shr_raw) % 64;
                7: r = int'(and_raw) % 64;
                8: r = int'(or_raw) % 64;
                9: r = int'(xor_raw) % 64;
                default: r = int'(mov_res);
            endcase
        end
        z = (r == 0);
        return {z, neg, c, err, r[11:0]};
    endfunction

    task automatic randomizeInputs();
        opcode   = OPW'($urandom_range(0, 15));
        sm_mode  = 1'($urandom);
        opb      = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
        sum_raw  = (N+1)'($urandom); sub_raw = (N+1)'($urandom); div_raw = (N+1)'($urandom);
        mod_raw  = (N+1)'($urandom); shl_raw = (N+1)'($urandom); shr_raw = (N+1)'($urandom);
        and_raw  = (N+1)'($urandom); or_raw  = (N+1)'($urandom); xor_raw = (N+1)'($urandom);
        mov_res  = N'($urandom); sum_sm = N'($urandom); sub_sm = N'($urandom);
        div_sm   = N'($urandom); mod_sm = N'($urandom);
        mult_raw = (2*N)'($urandom); mult_sm = (2*N)'($urandom);
    endtask

    // Sends one entry into an empty stage with out_ready high and checks it one cycle later.
    task automatic sendAndCheck(input string tag, input logic [11:0] expRes, input logic [3:0] expFlg);
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_vld"}, 16'(out_valid), 16'd1);
        check({tag, "_res"}, 16'(result), 16'(expRes));
        check({tag, "_flg"}, 16'(flags), 16'(expFlg));
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_vld", 16'(out_valid), 16'd0);
        check("rst_rdy", 16'(in_ready), 16'd1);
        check("rst_res", 16'(result), 16'd0);
        check("rst_flg", 16'(flags), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        opcode = 4'd0; sm_mode = 1'b0; sum_raw = 7'b1000011;
        sendAndCheck("add_carry", 12'h003, 4'b0010);

        opcode = 4'd2; sm_mode = 1'b1; mult_sm = 12'h83C; mult_raw = 12'h83C;
        sendAndCheck("mul_neg", 12'h83C, 4'b0110);

        opcode = 4'd3; sm_mode = 1'b1; opb = '0; div_sm = 6'h05;
        sendAndCheck("div_zero", 12'h000, 4'b1001);
`ifdef ALU_STAGE_STATS_EN
        check("stat_err1", err_count, 16'd1);
        check("stat_ops3", ops_count, 16'd3);
`endif

        opcode = 4'd13;
        sendAndCheck("illegal", 12'h000, 4'b1001);

        // Backpressure: three back-to-back offers with out_ready low
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        opcode = 4'd7; and_raw = 7'h05;
        @(negedge clk);
        check("bp_rdy1", 16'(in_ready), 16'd1);
        opcode = 4'd8; or_raw = 7'h07;
        @(negedge clk);
        check("bp_rdy2", 16'(in_ready), 16'd0);
        check("bp_head", 16'(result), 16'h005);
        opcode = 4'd9; xor_raw = 7'h02;
        @(negedge clk);
        check("bp_held_rdy", 16'(in_ready), 16'd0);
        check("bp_stable", 16'(result), 16'h005);
        check("bp_stable_v", 16'(out_valid), 16'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_drain2", 16'(result), 16'h007);
        check("bp_rdy3", 16'(in_ready), 16'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_drain3", 16'(result), 16'h002);
        check("bp_flg3", 16'(flags), 16'h0);
        @(negedge clk);
        check("bp_empty", 16'(out_valid), 16'd0);

`ifdef ALU_STAGE_STATS_EN
        opsModel = 7;
        errModel = 2;
`endif
        // Randomized traffic against the queue model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            check("rnd_vld", 16'(out_valid), 16'(modelQ.size() > 0));
            check("rnd_rdy", 16'(in_ready), 16'(modelQ.size() < 2));
            if (modelQ.size() > 0) begin
                check("rnd_dat", {flags, result}, modelQ[0]);
            end
            randomizeInputs();
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            expEntry  = refEntry();
            acc = in_valid && (modelQ.size() < 2);
            pop = out_ready && (modelQ.size() > 0);
            @(posedge clk);
            if (pop) void'(modelQ.pop_front());
            if (acc) begin
                modelQ.push_back(expEntry);
`ifdef ALU_STAGE_STATS_EN
                opsModel++;
                if (expEntry[12]) errModel++;
`endif
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef ALU_STAGE_STATS_EN
        check("stat_ops_rnd", ops_count, 16'(opsModel));
        check("stat_err_rnd", err_count, 16'(errModel));
`endif
        repeat (3) @(negedge clk);
        check("drain_empty", 16'(out_valid), 16'd0);

        // Reset while both entries are occupied
        out_ready = 1'b0; in_valid = 1'b1;
        opcode = 4'd7; and_raw = 7'h11;
        @(negedge clk);
        opcode = 4'd8; or_raw = 7'h22;
        @(negedge clk);
        in_valid = 1'b0;
        check("two_rdy", 16'(in_ready), 16'd0);
        rst_n = 1'b0;
        #1;
        check("arst_vld", 16'(out_valid), 16'd0);
        check("arst_rdy", 16'(in_ready), 16'd1);
        check("arst_res", 16'(result), 16'd0);
        check("arst_flg", 16'(flags), 16'd0);
`ifdef ALU_STAGE_STATS_EN
        check("arst_ops", ops_count, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        opcode = 4'd9; xor_raw = 7'h0C;
        sendAndCheck("post_rst", 12'h00C, 4'b0000);
        @(negedge clk);
        check("no_stale", 16'(out_valid), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
